// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-ported data RAM.
// Grants are round-robin on ties, and a holder is pre-empted after MAX_BURST acked cycles while contended.
module mem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_stall,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [1:0]  dbg_owner_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    owner_t        owner_q;
    logic          last_q;   // 0: master 0 held the grant last, 1: master 1
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          burst_done;

    // Saturating increment; hitting the cap also covers an owner that ran uncontended past MAX_BURST.
    assign cnt_d      = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    assign burst_done = (cnt_d == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (owner_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (m0_req && (!m1_req || last_q)) begin
                        owner_q <= OWN0;
                    end else if (m1_req) begin
                        owner_q <= OWN1;
                    end
                end
                OWN0: begin
                    if (m0_req) begin
                        if (m1_req && burst_done) begin
                            owner_q <= OWN1;
                            last_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        owner_q <= m1_req ? OWN1 : IDLE;
                        last_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                OWN1: begin
                    if (m1_req) begin
                        if (m0_req && burst_done) begin
                            owner_q <= OWN0;
                            last_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        owner_q <= m0_req ? OWN0 : IDLE;
                        last_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    owner_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign m0_ack      = (owner_q == OWN0) && m0_req;
    assign m1_ack      = (owner_q == OWN1) && m1_req;
    assign m0_stall    = m0_req && !m0_ack;
    assign m0_rdata    = (owner_q == OWN0) ? ram_rdata : 32'h0;
    assign m1_rdata    = (owner_q == OWN1) ? ram_rdata : 32'h0;
    assign dbg_owner_o = owner_q;

    // The RAM port is quiet unless the owner is actually requesting this cycle.
    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 32'h0;
        ram_sel   = 4'h0;
        ram_wdata = 32'h0;
        if (m0_ack) begin
            ram_ce    = 1'b1;
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_sel   = m0_sel;
            ram_wdata = m0_wdata;
        end else if (m1_ack) begin
            ram_ce    = 1'b1;
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_sel   = m1_sel;
            ram_wdata = m1_wdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter with MAX_BURST=4 (u_a, backed by a RAM model)
// and MAX_BURST=1 (u_b), both driven from the same master inputs.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;

    logic [31:0] a_m0_rdata, a_m1_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic        a_m0_ack, a_m1_ack, a_m0_stall, a_ram_ce, a_ram_we;
    logic [3:0]  a_ram_sel;
    logic [1:0]  a_dbg;

    logic [31:0] b_m0_rdata, b_m1_rdata, b_ram_addr, b_ram_wdata;
    logic        b_m0_ack, b_m1_ack, b_m0_stall, b_ram_ce, b_ram_we;
    logic [3:0]  b_ram_sel;
    logic [1:0]  b_dbg;
    wire  [31:0] b_ram_rdata = 32'hA5A5_0000;

    logic [31:0] mem [0:255] = '{default: 32'h0};

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_BURST(4)) u_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_stall(a_m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
        .ram_ce(a_ram_ce), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_sel(a_ram_sel),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .dbg_owner_o(a_dbg)
    );

    mem_arbiter #(.MAX_BURST(1)) u_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_stall(b_m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
        .ram_ce(b_ram_ce), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_sel(b_ram_sel),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .dbg_owner_o(b_dbg)
    );

    // Byte-lane RAM: writes commit on the clock edge, reads are combinational.
    always @(posedge clk) begin
        if (a_ram_ce && a_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_ram_sel[i]) mem[a_ram_addr[9:2]][8*i +: 8] <= a_ram_wdata[8*i +: 8];
            end
        end
    end
    assign a_ram_rdata = mem[a_ram_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_sel = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_sel = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        int w0a, w1a, w0b, w1b;
        logic e0, e1;
        idle_inputs();
        rst = 1'b0;
        m0_req = 1'b1;
        #2;
        chk("rst_m0_stall", {31'b0, a_m0_stall}, 32'h1);
        chk("rst_m0_ack", {31'b0, a_m0_ack}, 32'h0);
        chk("rst_ram_ce", {31'b0, a_ram_ce}, 32'h0);
        chk("rst_ram_addr", a_ram_addr, 32'h0);
        chk("rst_m0_rdata", a_m0_rdata, 32'h0);
        chk("rst_owner", {30'b0, a_dbg}, 32'h0);
        chk("rst_b_m0_stall", {31'b0, b_m0_stall}, 32'h1);
        m0_req = 1'b0;
        next_cycle();
        rst = 1'b1;

        // Single master write then read back.
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_sel = 4'hF; m0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_req_cycle_ack", {31'b0, a_m0_ack}, 32'h0);
        chk("wr_req_cycle_stall", {31'b0, a_m0_stall}, 32'h1);
        chk("wr_req_cycle_ce", {31'b0, a_ram_ce}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("wr_ack", {31'b0, a_m0_ack}, 32'h1);
        chk("wr_stall", {31'b0, a_m0_stall}, 32'h0);
        chk("wr_ram_we", {31'b0, a_ram_we}, 32'h1);
        chk("wr_ram_addr", a_ram_addr, 32'h10);
        chk("wr_ram_sel", {28'b0, a_ram_sel}, 32'hF);
        chk("wr_ram_wdata", a_ram_wdata, 32'hDEAD_BEEF);
        chk("wr_m1_ack", {31'b0, a_m1_ack}, 32'h0);
        chk("wr_owner", {30'b0, a_dbg}, 32'h1);
        next_cycle();
        m0_we = 0;
        @(negedge clk);
        chk("rd_ack", {31'b0, a_m0_ack}, 32'h1);
        chk("rd_ram_we", {31'b0, a_ram_we}, 32'h0);
        chk("rd_m0_rdata", a_m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_rdata", a_m1_rdata, 32'h0);
        chk("rd_m1_ack", {31'b0, a_m1_ack}, 32'h0);
        next_cycle();
        m0_req = 0;
        @(negedge clk);
        chk("drop_ce", {31'b0, a_ram_ce}, 32'h0);
        chk("drop_ack", {31'b0, a_m0_ack}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("drop_owner_idle", {30'b0, a_dbg}, 32'h0);

        // Tie after reset: master 0 first, then master 1 with no idle gap.
        next_cycle();
        do_reset();
        idle_inputs();
        m0_req = 1; m0_addr = 32'h10; m0_sel = 4'hF;
        m1_req = 1; m1_addr = 32'h10; m1_sel = 4'hF;
        @(negedge clk);
        chk("tie_idle_m0_ack", {31'b0, a_m0_ack}, 32'h0);
        chk("tie_idle_m1_ack", {31'b0, a_m1_ack}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("tie_m0_ack", {31'b0, a_m0_ack}, 32'h1);
        chk("tie_m1_ack", {31'b0, a_m1_ack}, 32'h0);
        chk("tie_owner", {30'b0, a_dbg}, 32'h1);
        next_cycle();
        m0_req = 0;
        @(negedge clk);
        chk("tie_drop_m1_ack", {31'b0, a_m1_ack}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("tie_hand_m1_ack", {31'b0, a_m1_ack}, 32'h1);
        chk("tie_hand_owner", {30'b0, a_dbg}, 32'h2);
        chk("tie_hand_m1_rdata", a_m1_rdata, 32'hDEAD_BEEF);
        chk("tie_hand_m0_rdata", a_m0_rdata, 32'h0);
        chk("tie_hand_ram_addr", a_ram_addr, 32'h10);

        // Continuous contention: 4/4 bursts on u_a, strict alternation on u_b.
        next_cycle();
        do_reset();
        idle_inputs();
        m0_req = 1; m0_addr = 32'h100;
        m1_req = 1; m1_addr = 32'h200;
        @(negedge clk);
        chk("burst_idle_ce", {31'b0, a_ram_ce}, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            next_cycle();
            @(negedge clk);
            e0 = (((k - 1) / 4) % 2) == 0;
            chk($sformatf("burst_a_m0_ack_%0d", k), {31'b0, a_m0_ack}, {31'b0, e0});
            chk($sformatf("burst_a_m1_ack_%0d", k), {31'b0, a_m1_ack}, {31'b0, !e0});
            chk($sformatf("burst_a_stall_%0d", k), {31'b0, a_m0_stall}, {31'b0, !e0});
            chk($sformatf("burst_a_addr_%0d", k), a_ram_addr, e0 ? 32'h100 : 32'h200);
            e1 = (k % 2) == 1;
            chk($sformatf("burst_b_m0_ack_%0d", k), {31'b0, b_m0_ack}, {31'b0, e1});
            chk($sformatf("burst_b_m1_ack_%0d", k), {31'b0, b_m1_ack}, {31'b0, !e1});
            chk($sformatf("burst_b_addr_%0d", k), b_ram_addr, e1 ? 32'h100 : 32'h200);
        end

        // Reset between edges while master 1 is writing.
        next_cycle();
        do_reset();
        idle_inputs();
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_sel = 4'hF; m1_wdata = 32'h55;
        next_cycle();
        #1;
        chk("rstw_ce_before", {31'b0, a_ram_ce}, 32'h1);
        chk("rstw_addr_before", a_ram_addr, 32'h20);
        #1;
        rst = 1'b0;
        #1;
        chk("rstw_ce", {31'b0, a_ram_ce}, 32'h0);
        chk("rstw_we", {31'b0, a_ram_we}, 32'h0);
        chk("rstw_addr", a_ram_addr, 32'h0);
        chk("rstw_wdata", a_ram_wdata, 32'h0);
        chk("rstw_m1_ack", {31'b0, a_m1_ack}, 32'h0);
        next_cycle();
        chk("rstw_mem_unchanged", mem[8], 32'h0);
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_sel = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_rel_idle_m0", {31'b0, a_m0_ack}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rstw_rel_m0_ack", {31'b0, a_m0_ack}, 32'h1);
        chk("rstw_rel_m1_ack", {31'b0, a_m1_ack}, 32'h0);
        chk("rstw_rel_mem", mem[8], 32'h0);

        // Random request/drop streams.
        w0a = 0; w1a = 0; w0b = 0; w1b = 0;
        for (int c = 0; c < 10000; c++) begin
            next_cycle();
            m0_req = ($urandom_range(0, 9) < 7);
            m1_req = ($urandom_range(0, 9) < 7);
            m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
            m0_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            m1_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            m0_sel = 4'($urandom_range(0, 15)); m1_sel = 4'($urandom_range(0, 15));
            m0_wdata = $urandom; m1_wdata = $urandom;
            @(negedge clk);
            chk("rnd_a_excl", {31'b0, a_m0_ack & a_m1_ack}, 32'h0);
            chk("rnd_b_excl", {31'b0, b_m0_ack & b_m1_ack}, 32'h0);
            chk("rnd_a_ce", {31'b0, a_ram_ce}, {31'b0, a_m0_ack | a_m1_ack});
            chk("rnd_b_ce", {31'b0, b_ram_ce}, {31'b0, b_m0_ack | b_m1_ack});
            chk("rnd_a_addr", a_ram_addr, a_m0_ack ? m0_addr : (a_m1_ack ? m1_addr : 32'h0));
            w0a = (m0_req && !a_m0_ack) ? w0a + 1 : 0;
            w1a = (m1_req && !a_m1_ack) ? w1a + 1 : 0;
            w0b = (m0_req && !b_m0_ack) ? w0b + 1 : 0;
            w1b = (m1_req && !b_m1_ack) ? w1b + 1 : 0;
            chk("rnd_a_starve", {31'b0, (w0a <= 5) && (w1a <= 5)}, 32'h1);
            chk("rnd_b_starve", {31'b0, (w0b <= 2) && (w1b <= 2)}, 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
